exe_wb_merger: RTL and testbench

Receiving end of the execute-stage writeback broadcast. It takes the three functional-unit writeback buses (ALU0/CSR/branch, ALU1, MUL/DIV), merges them onto the physical register file's two registered write ports, and reports the ROB tag of every result it writes. The two ALU pipes are never stalled. MUL/DIV results that lose arbitration are held in a small FIFO, with valid/ready backpressure to the MUL/DIV unit.

---
 rtl/exe_wb_merger.sv | 124 ++++++++++++
 tb/tb_exe_wb_merger.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_wb_merger.sv
// exe_wb_merger: merges the ALU0, ALU1 and MUL/DIV writeback buses onto the two
// registered PRF write ports. The ALU pipes always win. A MUL/DIV result that
// cannot be written is parked in a small in-order FIFO that backpressures MUL/DIV.
module exe_wb_merger #(
    parameter int DATA_W   = 32,
    parameter int PRF_AW   = 6,
    parameter int ROB_AW   = 5,
    parameter int MQ_DEPTH = 2,
    localparam int W       = 1 + 32 + ROB_AW + PRF_AW + DATA_W,
    localparam int CW      = $clog2(MQ_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [W-1:0]  a0_wb,
    input  logic [W-1:0]  a1_wb,
    input  logic [W-1:0]  md_wb,
    output logic          md_ready,
    output logic [W-1:0]  wp0,
    output logic [W-1:0]  wp1,
    output logic [CW-1:0] mq_count,
    output logic [15:0]   md_stall_cnt
);

    localparam int              PW      = (MQ_DEPTH > 1) ? $clog2(MQ_DEPTH) : 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(MQ_DEPTH);
    localparam logic [PW-1:0]   LAST_C  = PW'(MQ_DEPTH - 1);

    logic [W-1:0]  r_mem [MQ_DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_wp0;
    logic [W-1:0]  r_wp1;
    logic [15:0]   r_stall;

    logic          w_a0v, w_a1v, w_mdv;
    logic          w_ready, w_acc, w_qne, w_mv, w_mgnt, w_pop, w_push;
    logic [W-1:0]  w_mcand;
    logic [W-1:0]  w_nwp0, w_nwp1;

    assign w_a0v   = a0_wb[W-1];
    assign w_a1v   = a1_wb[W-1];
    assign w_mdv   = md_wb[W-1];

    // Ready comes only from registered occupancy, never from an input valid.
    assign w_ready = (r_count < DEPTH_C);
    assign w_acc   = w_mdv && w_ready && !flush;
    assign w_qne   = (r_count != '0);

    // Queued results always go first so MUL/DIV order is preserved.
    assign w_mcand = w_qne ? r_mem[r_rd] : md_wb;
    assign w_mv    = !flush && (w_qne || w_acc);
    assign w_mgnt  = w_mv && !(w_a0v && w_a1v);
    assign w_pop   = w_qne && w_mgnt;
    // An accepted input is queued unless it went straight to a port (empty FIFO, granted).
    assign w_push  = w_acc && !(!w_qne && w_mgnt);

    // Slot fill: a0 > a1 > M, first valid to port 0, second to port 1, rest zero.
    always_comb begin
        w_nwp0 = '0;
        w_nwp1 = '0;
        if (w_a0v) begin
            w_nwp0 = a0_wb;
            if (w_a1v)       w_nwp1 = a1_wb;
            else if (w_mgnt) w_nwp1 = w_mcand;
        end else if (w_a1v) begin
            w_nwp0 = a1_wb;
            if (w_mgnt)      w_nwp1 = w_mcand;
        end else if (w_mgnt) begin
            w_nwp0 = w_mcand;
        end
    end

    // Registered PRF write ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp0 <= '0;
            r_wp1 <= '0;
        end else begin
            r_wp0 <= w_nwp0;
            r_wp1 <= w_nwp1;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_pop)  r_rd <= (r_rd == LAST_C) ? '0 : r_rd + 1'b1;
            if (w_push) r_wr <= (r_wr == LAST_C) ? '0 : r_wr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the slot is not counted.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= md_wb;
    end

    // Saturating count of cycles MUL/DIV was held off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_stall <= '0;
        else if (w_mdv && !w_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end

    assign md_ready     = w_ready;
    assign wp0          = r_wp0;
    assign wp1          = r_wp1;
    assign mq_count     = r_count;
    assign md_stall_cnt = r_stall;

endmodule

// File: tb/tb_exe_wb_merger.sv
// Bench for exe_wb_merger: directed vector table, test-plan sequences, random
// traffic against a queue-based reference model, stall saturation and async reset.
module tb_exe_wb_merger;

    localparam int DATA_W   = 32;
    localparam int PRF_AW   = 6;
    localparam int ROB_AW   = 5;
    localparam int MQ_DEPTH = 2;
    localparam int W        = 1 + 32 + ROB_AW + PRF_AW + DATA_W;
    localparam int CW       = $clog2(MQ_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [W-1:0]  a0_wb, a1_wb, md_wb;
    logic          md_ready;
    logic [W-1:0]  wp0, wp1;
    logic [CW-1:0] mq_count;
    logic [15:0]   md_stall_cnt;

    exe_wb_merger #(
        .DATA_W(DATA_W), .PRF_AW(PRF_AW), .ROB_AW(ROB_AW), .MQ_DEPTH(MQ_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .a0_wb(a0_wb), .a1_wb(a1_wb), .md_wb(md_wb),
        .md_ready(md_ready), .wp0(wp0), .wp1(wp1),
        .mq_count(mq_count), .md_stall_cnt(md_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Distinct, recognisable bus for a given tag number.
    function automatic logic [W-1:0] mk(input logic [7:0] r);
        return {1'b1, 32'h0000_1000 + {24'h0, r}, r[ROB_AW-1:0], r[PRF_AW-1:0], {4{r}}};
    endfunction

    function automatic logic [W-1:0] mkv(input int v, input int r);
        return (v != 0) ? mk(8'(r)) : '0;
    endfunction

    function automatic logic [W-1:0] rbus(input logic v);
        return {v, 32'($urandom), ROB_AW'($urandom), PRF_AW'($urandom), 32'($urandom)};
    endfunction

    task automatic drive(input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] md, input logic fl);
        a0_wb = a0; a1_wb = a1; md_wb = md; flush = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive('0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int a0v, a1v, mdv, fl;
        int r0, r1, rm;
        int e0v, e0, e1v, e1;
        int cnt, rdy, stall;
    } vec_t;

    vec_t tbl[16];

    // Reference model: MUL/DIV queue plus saturating stall counter.
    logic [W-1:0] mq[$];
    int           mst;

    task automatic model(input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] md, input logic fl,
                         output logic rdy, output logic [W-1:0] e0, output logic [W-1:0] e1);
        logic [W-1:0] sl[$];
        rdy = (mq.size() < MQ_DEPTH);
        if (md[W-1] && !rdy && mst != 65535) mst++;
        sl = {};
        if (a0[W-1]) sl.push_back(a0);
        if (a1[W-1]) sl.push_back(a1);
        if (fl) mq = {};
        else begin
            if (md[W-1] && rdy) mq.push_back(md);
            if (sl.size() < 2 && mq.size() > 0) sl.push_back(mq.pop_front());
        end
        e0 = (sl.size() > 0) ? sl[0] : '0;
        e1 = (sl.size() > 1) ? sl[1] : '0;
    endtask

    initial begin
        logic [W-1:0] x, a0, a1, md, e0, e1;
        logic         fl, rdy, hold;

        rst = 1'b1;
        drive('0, '0, '0, 1'b0);
        tick(); tick();
        chk("rst_wp0", wp0, '0);
        chk("rst_wp1", wp1, '0);
        chk("rst_cnt", W'(mq_count), '0);
        chk("rst_stall", W'(md_stall_cnt), '0);
        chk("rst_rdy", W'(md_ready), W'(1));
        rst = 1'b0;
        tick();

        // a0 alone: addr 5, data 0x1234, rob 3.
        x = {1'b1, 32'h0000_0080, 5'd3, 6'd5, 32'h0000_1234};
        drive(x, '0, '0, 1'b0);
        tick();
        chk("a0_only_wp0", wp0, x);
        chk("a0_only_wp1", wp1, '0);
        chk("a0_only_cnt", W'(mq_count), '0);

        tbl[0]  = '{1,0,1,0,  1, 0, 2,  1, 1,1, 2,  0,1,0};
        tbl[1]  = '{1,1,1,0,  3, 4, 5,  1, 3,1, 4,  1,1,0};
        tbl[2]  = '{1,1,1,0,  6, 7, 8,  1, 6,1, 7,  2,1,0};
        tbl[3]  = '{1,1,1,0,  9,10,11,  1, 9,1,10,  2,0,1};
        tbl[4]  = '{0,0,1,0,  0, 0,11,  1, 5,0, 0,  1,0,2};
        tbl[5]  = '{0,0,1,0,  0, 0,11,  1, 8,0, 0,  1,1,2};
        tbl[6]  = '{0,0,0,0,  0, 0, 0,  1,11,0, 0,  0,1,2};
        tbl[7]  = '{1,1,1,0, 20,21,22,  1,20,1,21,  1,1,2};
        tbl[8]  = '{1,1,1,0, 23,24,25,  1,23,1,24,  2,1,2};
        tbl[9]  = '{1,0,1,1, 26, 0,27,  1,26,0, 0,  0,0,3};
        tbl[10] = '{0,0,0,0,  0, 0, 0,  0, 0,0, 0,  0,1,3};
        tbl[11] = '{1,1,1,0, 30,31, 7,  1,30,1,31,  1,1,3};
        tbl[12] = '{1,0,1,0, 32, 0, 9,  1,32,1, 7,  1,1,3};
        tbl[13] = '{0,0,0,0,  0, 0, 0,  1, 9,0, 0,  0,1,3};
        tbl[14] = '{0,1,1,0,  0,40,41,  1,40,1,41,  0,1,3};
        tbl[15] = '{0,0,1,0,  0, 0,42,  1,42,0, 0,  0,1,3};

        foreach (tbl[i]) begin
            drive(mkv(tbl[i].a0v, tbl[i].r0), mkv(tbl[i].a1v, tbl[i].r1),
                  mkv(tbl[i].mdv, tbl[i].rm), tbl[i].fl != 0);
            chk($sformatf("v%0d_rdy", i), W'(md_ready), W'(tbl[i].rdy));
            tick();
            chk($sformatf("v%0d_wp0", i), wp0, mkv(tbl[i].e0v, tbl[i].e0));
            chk($sformatf("v%0d_wp1", i), wp1, mkv(tbl[i].e1v, tbl[i].e1));
            chk($sformatf("v%0d_cnt", i), W'(mq_count), W'(tbl[i].cnt));
            chk($sformatf("v%0d_stall", i), W'(md_stall_cnt), W'(tbl[i].stall));
        end

        // Random traffic against the reference model.
        do_reset();
        mq = {};
        mst = 0;
        hold = 1'b0;
        md = '0;
        for (int c = 0; c < 3000; c++) begin
            a0 = rbus(1'($urandom_range(0, 1)));
            a1 = rbus(1'($urandom_range(0, 1)));
            if (!hold) md = rbus(1'($urandom_range(0, 2) != 0));
            fl = ($urandom_range(0, 15) == 0);
            drive(a0, a1, md, fl);
            model(a0, a1, md, fl, rdy, e0, e1);
            chk("rnd_rdy", W'(md_ready), W'(rdy));
            hold = md[W-1] && !rdy && !fl;
            tick();
            chk("rnd_wp0", wp0, e0);
            chk("rnd_wp1", wp1, e1);
            chk("rnd_cnt", W'(mq_count), W'(mq.size()));
            chk("rnd_stall", W'(md_stall_cnt), W'(mst));
        end

        // Saturate the stall counter, then reset mid-stream.
        do_reset();
        drive(mk(8'd50), mk(8'd51), mk(8'd52), 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", W'(md_stall_cnt), W'(16'hFFFF));
        chk("sat_cnt", W'(mq_count), W'(MQ_DEPTH));
        chk("sat_rdy", W'(md_ready), '0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wp0", wp0, '0);
        chk("arst_wp1", wp1, '0);
        chk("arst_cnt", W'(mq_count), '0);
        chk("arst_stall", W'(md_stall_cnt), '0);
        chk("arst_rdy", W'(md_ready), W'(1));
        tick();
        rst = 1'b0;
        drive('0, '0, '0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
